seq_div_top: RTL and testbench

- Sequential unsigned restoring divider: a 32-bit dividend over a 16-bit divisor gives a 16-bit quotient and a 16-bit remainder.
- Registered top level for the divide path, the inverse operation of the 16x16 multiplier datapath.
- Consumes product-width operands from the multiplier side and returns factor-width results.
- Valid/ready handshake on both ends; one quotient bit resolved per clock.

---
 rtl/seq_div_top_if.sv | 25 ++
 rtl/seq_div_top.sv | 154 +++++++++++++++
 tb/tb_seq_div_top.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_div_top_if.sv
// Handshake bundle for the sequential divider: operand channel in, result channel out.
interface seq_div_top_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic                 ovf;
  logic                 dbz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, ovf, dbz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, ovf, dbz
  );
endinterface

// File: rtl/seq_div_top.sv
// Sequential unsigned restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient and remainder.
// Optional round-half-up of the quotient when SEQ_DIV_ROUND_EN is defined.
module seq_div_top #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  seq_div_top_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SEQ_DIV_ROUND_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ROUND = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovfp_q, ovfp_d;
  logic             dbzp_q, dbzp_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

`ifdef SEQ_DIV_ROUND_EN
  // Returns {ovf, q}: round half up, saturating at all-ones.
  function automatic logic [WIDTH:0] round_q(input logic [WIDTH-1:0] quo,
                                              input logic [WIDTH-1:0] rem,
                                              input logic [WIDTH-1:0] div);
    logic [WIDTH:0] r2;
    r2 = {rem, 1'b0};
    if (r2 < {1'b0, div})  return {1'b0, quo};
    if (&quo)              return {1'b1, quo};
    return {1'b0, quo + WIDTH'(1)};
  endfunction
`endif

  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  logic [WIDTH:0] shift_w;
  logic [WIDTH:0] diff_w;
  logic           ge_w;
  assign shift_w = {rem_q, quo_q[WIDTH-1]};
  assign diff_w  = shift_w - {1'b0, b_q};
  assign ge_w    = (shift_w >= {1'b0, b_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      ovfp_q  <= 1'b0;
      dbzp_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      ovfp_q  <= ovfp_d;
      dbzp_q  <= dbzp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    ovfp_d  = ovfp_q;
    dbzp_d  = dbzp_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          b_d     = bus.b;
          cnt_d   = '0;
          ovfp_d  = 1'b0;
          dbzp_d  = 1'b0;
          state_d = S_RUN;
          // Exceptions stage their result in rem/quo and finish on the first RUN cycle.
          if (bus.b == '0) begin
            dbzp_d = 1'b1;
            quo_d  = '1;
            rem_d  = bus.a[WIDTH-1:0];
          end else if (bus.a[2*WIDTH-1:WIDTH] >= bus.b) begin
            ovfp_d = 1'b1;
            quo_d  = '1;
            rem_d  = '0;
          end else begin
            rem_d = bus.a[2*WIDTH-1:WIDTH];
            quo_d = bus.a[WIDTH-1:0];
          end
        end
      end
      S_RUN: begin
        if (ovfp_q || dbzp_q || (cnt_q == CNT_LAST)) begin
          q_d   = quo_q;
          r_d   = rem_q;
          ovf_d = ovfp_q;
          dbz_d = dbzp_q;
`ifdef SEQ_DIV_ROUND_EN
          state_d = (ovfp_q || dbzp_q) ? S_DONE : S_ROUND;
`else
          state_d = S_DONE;
`endif
        end else begin
          rem_d = ge_w ? diff_w[WIDTH-1:0] : shift_w[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge_w};
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef SEQ_DIV_ROUND_EN
      S_ROUND: begin
        {ovf_d, q_d} = round_q(quo_q, rem_q, b_q);
        state_d      = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div_top.sv
// Scoreboard bench for seq_div_top: expected results are queued at issue and compared at completion.
module tb_seq_div_top;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dbz;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  seq_div_top_if #(.WIDTH(W)) bus ();

  seq_div_top #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] qq, rr;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.dbz = 1'b1; e.q = '1; e.r = a[W-1:0]; e.lat = 1;
    end else if (a[2*W-1:W] >= b) begin
      e.ovf = 1'b1; e.q = '1; e.r = '0; e.lat = 1;
    end else begin
      qq = a / {16'd0, b};
      rr = a % {16'd0, b};
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
      e.lat = W + 1;
`ifdef SEQ_DIV_ROUND_EN
      e.lat = W + 2;
      if ({1'b0, rr[W-1:0], 1'b0} >= {2'b0, b}) begin
        if (&e.q) e.ovf = 1'b1;
        else      e.q = e.q + 16'd1;
      end
`endif
    end
    return e;
  endfunction

  task automatic send_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < 40 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_rdy", {63'd0, bus.in_ready}, 64'd0);
  endtask

  task automatic recv_op();
    exp_t e;
    int   n;
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      n = k;
      if (bus.out_valid) break;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      chk("timeout", 64'd0, 64'd1);
      return;
    end
    chk("lat", 64'(n), 64'(e.lat));
    chk("q",   {48'd0, bus.q}, {48'd0, e.q});
    chk("r",   {48'd0, bus.r}, {48'd0, e.r});
    chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
    chk("dbz", {63'd0, bus.dbz}, {63'd0, e.dbz});
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("ack_rdy", {63'd0, bus.in_ready}, 64'd1);
    chk("ack_ov",  {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic run_div(input logic [2*W-1:0] a, input logic [W-1:0] b);
    send_op(a, b);
    recv_op();
    ack();
  endtask

  initial begin
    logic [W-1:0]   hq, hr, rb;
    logic [2*W-1:0] ra;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rdy", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_ov",  {63'd0, bus.out_valid}, 64'd0);
    chk("rst_q",   {48'd0, bus.q}, 64'd0);
    chk("rst_r",   {48'd0, bus.r}, 64'd0);
    chk("rst_flg", {62'd0, bus.ovf, bus.dbz}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_div(32'd1000, 16'd7);
    run_div(32'hFFFE0001, 16'hFFFF);
    run_div(32'h00010000, 16'h0001);
    run_div(32'h12345678, 16'h0000);
    run_div(32'h0000FFFF, 16'h0002);
    run_div(32'd0, 16'd5);

    // Backpressure: result must hold and new operands must be ignored
    send_op(32'd1000, 16'd7);
    recv_op();
    hq = bus.q;
    hr = bus.r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h00000033;
      bus.b        = 16'd3;
      @(posedge clk); #1;
      chk("bp_q",   {48'd0, bus.q}, {48'd0, hq});
      chk("bp_r",   {48'd0, bus.r}, {48'd0, hr});
      chk("bp_rdy", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_ov",  {63'd0, bus.out_valid}, 64'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    ack();

    // Asynchronous reset in the middle of an iteration run
    send_op(32'd1000, 16'd7);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov",  {63'd0, bus.out_valid}, 64'd0);
    chk("arst_rdy", {63'd0, bus.in_ready}, 64'd1);
    chk("arst_q",   {48'd0, bus.q}, 64'd0);
    chk("arst_r",   {48'd0, bus.r}, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd1000, 16'd7);

    // Random non-exceptional operands
    for (int i = 0; i < 2000; i++) begin
      rb = 16'($urandom_range(1, 65535));
      ra = {16'($urandom_range(0, int'(rb) - 1)), 16'($urandom)};
      send_op(ra, rb);
      recv_op();
`ifndef SEQ_DIV_ROUND_EN
      chk("inv",  64'(bus.q) * 64'(rb) + 64'(bus.r), 64'(ra));
      chk("r_lt_b", {63'd0, (bus.r < rb)}, 64'd1);
`endif
      ack();
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
